// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// Completion monitor for the open_risc_v SoC. It snoops the register-file
// write port and shadows the two signature registers and the test-number
// register. A write of 1 to either signature register starts a drain window,
// and at its end a pass/fail verdict is latched. If no trigger arrives in
// time, a timeout verdict is latched instead. All verdict outputs are sticky
// until rst or clr.
module riscv_test_monitor #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int PASS_REG_A     = 26,
  parameter int PASS_REG_B     = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] test_num,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // drain_cnt only needs to reach DRAIN_CYCLES-1; keep at least one bit.
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST   = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  ADDR_A       = ADDR_W'(PASS_REG_A);
  localparam logic [ADDR_W-1:0]  ADDR_B       = ADDR_W'(PASS_REG_B);
  localparam logic [ADDR_W-1:0]  ADDR_T       = ADDR_W'(TESTNUM_REG);
  localparam logic [DATA_W-1:0]  ONE          = DATA_W'(1);

  logic [1:0]         state, state_d;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_d;
  logic [DATA_W-1:0]  sig_a, sig_b;
  logic [DATA_W-1:0]  sig_a_next, sig_b_next;
  logic               done_d, pass_d, fail_d, timeout_d;
  logic               verdict_pass;
  logic [CNT_W-1:0]   cycle_count_d;
  logic               wr_valid, hit_a, hit_b, hit_t, trigger;

  // Decode the snooped write: x0 writes never count, whatever the index.
  always_comb begin
    wr_valid   = rf_we && (rf_waddr != '0);
    hit_a      = wr_valid && (rf_waddr == ADDR_A);
    hit_b      = wr_valid && (rf_waddr == ADDR_B);
    hit_t      = wr_valid && (rf_waddr == ADDR_T);
    trigger    = (hit_a || hit_b) && (rf_wdata == ONE);
    // The verdict must see a signature write landing on the verdict edge.
    sig_a_next   = hit_a ? rf_wdata : sig_a;
    sig_b_next   = hit_b ? rf_wdata : sig_b;
    verdict_pass = (sig_a_next == ONE) && (sig_b_next == ONE);
  end

  // Next-state, drain counter and verdict logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state;
    drain_cnt_d = drain_cnt;
    done_d      = done;
    pass_d      = pass;
    fail_d      = fail;
    timeout_d   = timeout;
    case (state)
      RUN: begin
        // Trigger wins over a timeout landing on the same edge.
        if (trigger) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (cycle_count == TIMEOUT_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = verdict_pass;
          fail_d  = !verdict_pass;
        end else begin
          drain_cnt_d = drain_cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Cycle counter: counts while RUN or DRAIN, saturates, freezes in DONE.
  always_comb begin
    cycle_count_d = cycle_count;
    if ((state != DONE) && (cycle_count != '1)) begin
      cycle_count_d = cycle_count + 1'b1;
    end
  end

  // State, shadow and output registers; clr behaves like a synchronous reset
  // and discards any write presented on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state       <= RUN;
      drain_cnt   <= '0;
      sig_a       <= '0;
      sig_b       <= '0;
      test_num    <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else if (clr) begin
      state       <= RUN;
      drain_cnt   <= '0;
      sig_a       <= '0;
      sig_b       <= '0;
      test_num    <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      drain_cnt   <= drain_cnt_d;
      cycle_count <= cycle_count_d;
      done        <= done_d;
      pass        <= pass_d;
      fail        <= fail_d;
      timeout     <= timeout_d;
      // Shadows track writes in RUN and DRAIN; everything is frozen in DONE.
      if (state != DONE) begin
        sig_a <= sig_a_next;
        sig_b <= sig_b_next;
        if (hit_t) begin
          test_num <= rf_wdata;
        end
      end
    end
  end

endmodule
